hilo_unit: RTL

Multi-cycle multiply/divide engine and HI/LO register pair, directly downstream of the ALU. It takes the ALU's single-cycle HI/LO write path (mthi/mtlo) and replaces the combinational multu/divu result with a 32-iteration sequential engine that exposes a busy/done handshake. The block owns the architectural HI and LO registers and drives them back to the ALU for mfhi/mflo.

---
 rtl/hilo_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - sequential unsigned multiply/divide engine owning the HI/LO register pair
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             w_hilo,
  input  logic [WIDTH-1:0] write_hi,
  input  logic [WIDTH-1:0] write_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Multiply: {partial product, multiplier}. Divide: low half is dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Control sequencing: IDLE -> RUN for WIDTH steps -> one DONE cycle -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus the final result select
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div_q) begin
      // A zero divisor already yields these values; selecting them explicitly pins the contract.
      res_hi = zero_q ? a_q : rem_q[WIDTH-1:0];
      res_lo = zero_q ? '1 : acc_q[WIDTH-1:0];
    end else begin
      res_hi = acc_q[2*WIDTH-1:WIDTH];
      res_lo = acc_q[WIDTH-1:0];
    end
  end

  // Operand capture at launch and datapath stepping while running
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    zero_d   = zero_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    if (state_q == S_IDLE && start) begin
      cnt_d    = '0;
      is_div_d = is_div;
      zero_d   = (src_b == '0);
      a_d      = src_a;
      b_d      = src_b;
      rem_d    = '0;
      acc_d    = {{WIDTH{1'b0}}, (is_div ? src_a : src_b)};
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        rem_d = div_ge ? div_diff : div_shift;
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  // HI/LO update: engine commit in DONE takes priority over the direct write
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_DONE) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (w_hilo) begin
      hi_d = write_hi;
      lo_d = write_lo;
    end
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      zero_q   <= zero_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = (state_q == S_DONE) && is_div_q && zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
